enemy_hit_tracker: RTL and testbench

- Downstream consumer of the bullet state block's outputs: the two bullet positions (sprite12/sprite13) and the is_shot_1/is_shot_2 flags.
- Tests each live bullet against one enemy sprite's bounding box once per frame.
- Applies damage and runs invincibility, dying and dead phases.
- Drives the enemy health, hit pulse, flash, dead and kill-count signals used by the sprite compositor and the score display.

---
 rtl/enemy_hit_tracker_if.sv | 31 +++
 rtl/enemy_hit_tracker.sv | 146 ++++++++++++++
 tb/tb_enemy_hit_tracker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_hit_tracker_if.sv
// Bundles the bullet/enemy positions and the enemy status outputs of the hit tracker.
// The master modport drives the positions and shot flags; the slave modport reports the enemy status.
interface enemy_hit_tracker_if;
  logic       is_shot_1;
  logic       is_shot_2;
  logic [9:0] sprite12xr;
  logic [9:0] sprite12yr;
  logic [9:0] sprite13xr;
  logic [9:0] sprite13yr;
  logic [9:0] sprite1xr;
  logic [9:0] sprite1yr;
  logic       respawn;
  logic [3:0] enemy_health;
  logic       enemy_hit;
  logic       enemy_flash;
  logic       enemy_dead;
  logic       enemy_active;
  logic [7:0] kill_count;

  modport master (
    output is_shot_1, is_shot_2, sprite12xr, sprite12yr, sprite13xr, sprite13yr,
           sprite1xr, sprite1yr, respawn,
    input  enemy_health, enemy_hit, enemy_flash, enemy_dead, enemy_active, kill_count
  );

  modport slave (
    input  is_shot_1, is_shot_2, sprite12xr, sprite12yr, sprite13xr, sprite13yr,
           sprite1xr, sprite1yr, respawn,
    output enemy_health, enemy_hit, enemy_flash, enemy_dead, enemy_active, kill_count
  );
endinterface

// File: rtl/enemy_hit_tracker.sv
// Per-frame bullet/enemy collision, damage, invincibility and death sequencing for one enemy.
// Each bullet hits at most once per shot; the shot must drop before it can hit again.
module enemy_hit_tracker #(
  parameter int BULLET_W     = 8,
  parameter int BULLET_H     = 8,
  parameter int ENEMY_W      = 32,
  parameter int ENEMY_H      = 32,
  parameter int MAX_HEALTH   = 10,
  parameter int DAMAGE       = 1,
  parameter int IFRAMES      = 8,
  parameter int DEATH_FRAMES = 30
) (
  input logic                 frame_clk,
  input logic                 Reset,
  enemy_hit_tracker_if.slave  bus
);

  typedef enum logic [1:0] {ALIVE, INVULN, DYING, DEAD} state_t;

  localparam int TMAX = (IFRAMES > DEATH_FRAMES) ? IFRAMES : DEATH_FRAMES;
  localparam int TW   = (TMAX > 4) ? $clog2(TMAX) : 2;

  localparam logic [TW-1:0] IFR_LAST   = TW'(IFRAMES - 1);
  localparam logic [TW-1:0] DEATH_LAST = TW'(DEATH_FRAMES - 1);
  localparam logic [10:0]   BW         = 11'(BULLET_W);
  localparam logic [10:0]   BH         = 11'(BULLET_H);
  localparam logic [10:0]   EW         = 11'(ENEMY_W);
  localparam logic [10:0]   EH         = 11'(ENEMY_H);
  localparam logic [3:0]    MAX_H      = 4'(MAX_HEALTH);
  localparam logic [7:0]    DAMAGE_8   = 8'(DAMAGE);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    health_q, health_d;
  logic          hit_q, hit_d;
  logic [7:0]    kill_q, kill_d;
  logic          spent1_q, spent1_d;
  logic          spent2_q, spent2_d;

  logic       active;
  logic       ov1, ov2, hit1, hit2;
  logic [1:0] n_hits;
  logic [7:0] dmg;
  logic [3:0] new_health;

  // Coordinates are widened to 11 bits so boxes near the right/bottom edge never wrap.
  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] ex, input logic [9:0] ey);
    logic [10:0] bx11, by11, ex11, ey11;
    bx11 = {1'b0, bx};
    by11 = {1'b0, by};
    ex11 = {1'b0, ex};
    ey11 = {1'b0, ey};
    return (bx11 < ex11 + EW) && (bx11 + BW > ex11) &&
           (by11 < ey11 + EH) && (by11 + BH > ey11);
  endfunction

  always_comb begin
    active     = (state_q == ALIVE) || (state_q == INVULN);
    ov1        = overlap(bus.sprite12xr, bus.sprite12yr, bus.sprite1xr, bus.sprite1yr);
    ov2        = overlap(bus.sprite13xr, bus.sprite13yr, bus.sprite1xr, bus.sprite1yr);
    hit1       = bus.is_shot_1 && ov1 && !spent1_q && active;
    hit2       = bus.is_shot_2 && ov2 && !spent2_q && active;
    spent1_d   = bus.is_shot_1 ? (spent1_q | hit1) : 1'b0;
    spent2_d   = bus.is_shot_2 ? (spent2_q | hit2) : 1'b0;
    n_hits     = {1'b0, hit1} + {1'b0, hit2};
    dmg        = {6'd0, n_hits} * DAMAGE_8;
    new_health = ({4'd0, health_q} > dmg) ? (health_q - dmg[3:0]) : 4'd0;

    state_d  = state_q;
    timer_d  = timer_q;
    health_d = health_q;
    hit_d    = 1'b0;
    kill_d   = kill_q;

    case (state_q)
      ALIVE: begin
        if (dmg != 8'd0) begin
          hit_d    = 1'b1;
          health_d = new_health;
          if (new_health == 4'd0) begin
            state_d = DYING;
            timer_d = DEATH_LAST;
            kill_d  = (kill_q == 8'hFF) ? kill_q : kill_q + 8'd1;
          end else begin
            state_d = INVULN;
            timer_d = IFR_LAST;
          end
        end
      end
      INVULN: begin
        if (timer_q == '0) state_d = ALIVE;
        else               timer_d = timer_q - 1'b1;
      end
      DYING: begin
        if (timer_q == '0) state_d = DEAD;
        else               timer_d = timer_q - 1'b1;
      end
      DEAD: begin
        if (bus.respawn) begin
          state_d  = ALIVE;
          health_d = MAX_H;
          timer_d  = '0;
        end
      end
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= ALIVE;
      timer_q  <= '0;
      health_q <= MAX_H;
      hit_q    <= 1'b0;
      kill_q   <= 8'd0;
      spent1_q <= 1'b0;
      spent2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      health_q <= health_d;
      hit_q    <= hit_d;
      kill_q   <= kill_d;
      spent1_q <= spent1_d;
      spent2_q <= spent2_d;
    end
  end

  // Flash blinks slowly while invincible and quickly while dying.
  always_comb begin
    bus.enemy_flash = 1'b0;
    case (state_q)
      INVULN:  bus.enemy_flash = timer_q[1];
      DYING:   bus.enemy_flash = timer_q[0];
      default: bus.enemy_flash = 1'b0;
    endcase
  end

  assign bus.enemy_health = health_q;
  assign bus.enemy_hit    = hit_q;
  assign bus.enemy_dead   = (state_q == DEAD);
  assign bus.enemy_active = (state_q == ALIVE) || (state_q == INVULN);
  assign bus.kill_count   = kill_q;

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Checks enemy_hit_tracker against a frame-level behavioural model on every frame,
// plus directed scenarios with hand-computed expectations.
module tb_enemy_hit_tracker;

  localparam int BULLET_W     = 8;
  localparam int BULLET_H     = 8;
  localparam int ENEMY_W      = 32;
  localparam int ENEMY_H      = 32;
  localparam int MAX_HEALTH   = 10;
  localparam int DAMAGE       = 1;
  localparam int IFRAMES      = 8;
  localparam int DEATH_FRAMES = 30;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  bit   cmp_on    = 1'b0;

  enemy_hit_tracker_if bus ();

  enemy_hit_tracker #(
    .BULLET_W(BULLET_W), .BULLET_H(BULLET_H), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H),
    .MAX_HEALTH(MAX_HEALTH), .DAMAGE(DAMAGE), .IFRAMES(IFRAMES), .DEATH_FRAMES(DEATH_FRAMES)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  // Model: remaining frames of invincibility/dying rather than a state code.
  int m_health = MAX_HEALTH;
  int m_kills = 0;
  int m_inv_left = 0;
  int m_dying_left = 0;
  bit m_dead = 0;
  bit m_spent1 = 0;
  bit m_spent2 = 0;
  bit m_hit = 0;

  function automatic bit boxes_overlap(int bx, int by, int ex, int ey);
    return (bx < ex + ENEMY_W) && (bx + BULLET_W > ex) && (by < ey + ENEMY_H) && (by + BULLET_H > ey);
  endfunction

  function automatic bit model_active();
    return !m_dead && (m_dying_left == 0);
  endfunction

  function automatic int model_flash();
    if (m_inv_left > 0)   return ((m_inv_left - 1) / 2) % 2;
    if (m_dying_left > 0) return (m_dying_left - 1) % 2;
    return 0;
  endfunction

  always @(posedge frame_clk) begin
    bit h1, h2;
    int dmg;
    if (Reset) begin
      m_health = MAX_HEALTH; m_kills = 0; m_inv_left = 0; m_dying_left = 0;
      m_dead = 0; m_spent1 = 0; m_spent2 = 0; m_hit = 0;
    end else begin
      h1 = bus.is_shot_1 && !m_spent1 && model_active() &&
           boxes_overlap(int'(bus.sprite12xr), int'(bus.sprite12yr), int'(bus.sprite1xr), int'(bus.sprite1yr));
      h2 = bus.is_shot_2 && !m_spent2 && model_active() &&
           boxes_overlap(int'(bus.sprite13xr), int'(bus.sprite13yr), int'(bus.sprite1xr), int'(bus.sprite1yr));
      m_spent1 = bus.is_shot_1 ? (m_spent1 | h1) : 1'b0;
      m_spent2 = bus.is_shot_2 ? (m_spent2 | h2) : 1'b0;
      m_hit = 0;
      if (m_dead) begin
        if (bus.respawn) begin
          m_dead = 0;
          m_health = MAX_HEALTH;
        end
      end else if (m_dying_left > 0) begin
        m_dying_left--;
        if (m_dying_left == 0) m_dead = 1;
      end else if (m_inv_left > 0) begin
        m_inv_left--;
      end else begin
        dmg = (int'(h1) + int'(h2)) * DAMAGE;
        if (dmg > 0) begin
          m_hit = 1;
          if (dmg >= m_health) begin
            m_health = 0;
            m_kills = (m_kills < 255) ? m_kills + 1 : 255;
            m_dying_left = DEATH_FRAMES;
          end else begin
            m_health -= dmg;
            m_inv_left = IFRAMES;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge frame_clk) begin
    if (cmp_on) begin
      checkOutput("model_health", int'(bus.enemy_health), m_health);
      checkOutput("model_hit",    int'(bus.enemy_hit),    int'(m_hit));
      checkOutput("model_flash",  int'(bus.enemy_flash),  model_flash());
      checkOutput("model_dead",   int'(bus.enemy_dead),   int'(m_dead));
      checkOutput("model_active", int'(bus.enemy_active), int'(model_active()));
      checkOutput("model_kills",  int'(bus.kill_count),   m_kills);
    end
  end

  task automatic applyStimulus(input bit s1, input bit s2, input int x1, input int y1,
                               input int x2, input int y2, input bit resp);
    bus.is_shot_1  = s1;
    bus.is_shot_2  = s2;
    bus.sprite12xr = 10'(x1);
    bus.sprite12yr = 10'(y1);
    bus.sprite13xr = 10'(x2);
    bus.sprite13yr = 10'(y2);
    bus.respawn    = resp;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(1);
    Reset = 1'b0;
  endtask

  // Nine spaced-out single hits leave the enemy at health 1 and ALIVE.
  task automatic wearDown();
    for (int i = 0; i < MAX_HEALTH - 1; i++) begin
      applyStimulus(1, 0, 305, 210, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 305, 210, 0, 0, 0);
      step(9);
    end
  endtask

  initial begin
    bus.sprite1xr = 10'd300;
    bus.sprite1yr = 10'd200;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(1);
    cmp_on = 1'b1;
    step(1);
    Reset = 1'b0;
    checkOutput("reset_health", int'(bus.enemy_health), 10);
    checkOutput("reset_active", int'(bus.enemy_active), 1);
    checkOutput("reset_kills",  int'(bus.kill_count), 0);

    applyStimulus(1, 0, 295, 210, 0, 0, 0);
    step(1);
    checkOutput("first_hit_health", int'(bus.enemy_health), 9);
    checkOutput("first_hit_pulse",  int'(bus.enemy_hit), 1);
    checkOutput("first_hit_flash",  int'(bus.enemy_flash), 1);
    checkOutput("model_pin_health", m_health, 9);
    step(1);
    checkOutput("held_shot_no_pulse", int'(bus.enemy_hit), 0);
    checkOutput("invuln_flash_t6",    int'(bus.enemy_flash), 1);
    step(1);
    checkOutput("invuln_flash_t5",    int'(bus.enemy_flash), 0);
    applyStimulus(0, 0, 295, 210, 0, 0, 0);
    step(8);
    checkOutput("back_alive_flash",  int'(bus.enemy_flash), 0);
    checkOutput("back_alive_health", int'(bus.enemy_health), 9);

    doReset();
    applyStimulus(1, 0, 332, 210, 0, 0, 0);
    step(1);
    checkOutput("edge_touch_no_hit", int'(bus.enemy_health), 10);
    applyStimulus(1, 0, 331, 210, 0, 0, 0);
    step(1);
    checkOutput("edge_inside_hit", int'(bus.enemy_health), 9);

    doReset();
    applyStimulus(1, 1, 305, 205, 310, 215, 0);
    step(1);
    checkOutput("double_hit_health", int'(bus.enemy_health), 8);
    checkOutput("double_hit_pulse",  int'(bus.enemy_hit), 1);
    checkOutput("model_pin_double",  m_health, 8);
    step(1);
    checkOutput("double_hit_single_pulse", int'(bus.enemy_hit), 0);

    doReset();
    wearDown();
    checkOutput("worn_health", int'(bus.enemy_health), 1);
    applyStimulus(1, 0, 305, 210, 0, 0, 0);
    step(1);
    checkOutput("fatal_health", int'(bus.enemy_health), 0);
    checkOutput("fatal_active", int'(bus.enemy_active), 0);
    checkOutput("fatal_kills",  int'(bus.kill_count), 1);
    applyStimulus(0, 0, 305, 210, 0, 0, 1);
    step(DEATH_FRAMES - 1);
    checkOutput("dying_last_frame_dead", int'(bus.enemy_dead), 0);
    applyStimulus(0, 0, 305, 210, 0, 0, 0);
    step(1);
    checkOutput("dead_flag",   int'(bus.enemy_dead), 1);
    checkOutput("dead_kills",  int'(bus.kill_count), 1);
    checkOutput("model_pin_dead", int'(m_dead), 1);
    applyStimulus(0, 0, 305, 210, 0, 0, 1);
    step(1);
    applyStimulus(0, 0, 305, 210, 0, 0, 0);
    checkOutput("respawn_health", int'(bus.enemy_health), 10);
    checkOutput("respawn_active", int'(bus.enemy_active), 1);

    doReset();
    applyStimulus(1, 0, 305, 210, 0, 0, 0);
    step(1);
    applyStimulus(0, 1, 305, 210, 310, 215, 0);
    step(1);
    checkOutput("invuln_ignores_hit", int'(bus.enemy_health), 9);
    step(10);
    checkOutput("spent_bullet_no_damage", int'(bus.enemy_health), 9);
    applyStimulus(0, 0, 305, 210, 310, 215, 0);
    step(1);
    applyStimulus(0, 1, 305, 210, 310, 215, 0);
    step(1);
    checkOutput("rearmed_bullet_health", int'(bus.enemy_health), 8);
    checkOutput("rearmed_bullet_pulse",  int'(bus.enemy_hit), 1);

    doReset();
    wearDown();
    applyStimulus(1, 0, 305, 210, 0, 0, 0);
    step(5);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    checkOutput("reset_in_dying_health", int'(bus.enemy_health), 10);
    checkOutput("reset_in_dying_kills",  int'(bus.kill_count), 0);
    checkOutput("reset_in_dying_active", int'(bus.enemy_active), 1);
    checkOutput("reset_in_dying_flash",  int'(bus.enemy_flash), 0);
    checkOutput("reset_in_dying_hit",    int'(bus.enemy_hit), 0);

    for (int f = 0; f < 4000; f++) begin
      int ex, ey;
      if ($urandom_range(0, 15) == 0) begin
        ex = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
        ey = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
        bus.sprite1xr = 10'(ex);
        bus.sprite1yr = 10'(ey);
      end
      ex = int'(bus.sprite1xr);
      ey = int'(bus.sprite1yr);
      if ($urandom_range(0, 3) == 0)
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      (ex + $urandom_range(0, 52) - 10) & 1023, (ey + $urandom_range(0, 52) - 10) & 1023,
                      (ex + $urandom_range(0, 52) - 10) & 1023, (ey + $urandom_range(0, 52) - 10) & 1023,
                      $urandom_range(0, 7) == 0);
      else begin
        if ($urandom_range(0, 5) == 0) bus.is_shot_1 = ~bus.is_shot_1;
        if ($urandom_range(0, 5) == 0) bus.is_shot_2 = ~bus.is_shot_2;
        bus.respawn = ($urandom_range(0, 7) == 0);
      end
      Reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    Reset = 1'b0;
    step(1);
    cmp_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
